// File: rtl/uart_rx_frame_assembler.sv
// Receives bytes from a UART and finds frames that start with the header 0xAA 0x55.
// Each R,G,B triple becomes one pixel with x/y coordinates. A trailing byte checks the sum of the payload.
module uart_rx_frame_assembler #(
  parameter int WIDTH   = 10,
  parameter int HEIGHT  = 1,
  parameter int TIMEOUT = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       rx_err,
  output logic [7:0] pix_red,
  output logic [7:0] pix_green,
  output logic [7:0] pix_blue,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_valid,
  output logic       frame_done,
  output logic       frame_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    PAYLOAD = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int             IW     = $clog2(TIMEOUT + 1);
  localparam logic [9:0]     X_LAST = 10'(WIDTH - 1);
  localparam logic [9:0]     Y_LAST = 10'(HEIGHT - 1);
  localparam logic [IW-1:0]  TO_END = IW'(TIMEOUT - 1);

  state_t        state_q;
  logic          rx_done_q;
  logic [1:0]    comp;
  logic [9:0]    x_cnt;
  logic [9:0]    y_cnt;
  logic [7:0]    sum;
  logic [7:0]    r_buf;
  logic [7:0]    g_buf;
  logic [IW-1:0] idle_cnt;
  logic          accept;
  logic          active;
  logic          timeout;

  assign accept  = rx_done & ~rx_done_q;
  assign active  = (state_q == SYNC) || (state_q == PAYLOAD) || (state_q == CHECK);
  // An accepted byte always restarts the idle count, so it outranks the timeout.
  assign timeout = active && !accept && (idle_cnt == TO_END);
  assign state   = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rx_done_q  <= 1'b0;
      comp       <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      sum        <= '0;
      r_buf      <= '0;
      g_buf      <= '0;
      idle_cnt   <= '0;
      pix_red    <= '0;
      pix_green  <= '0;
      pix_blue   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_done_q  <= rx_done;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;

      if (accept)
        idle_cnt <= '0;
      else if (active)
        idle_cnt <= idle_cnt + 1'b1;

      if (timeout) begin
        frame_err <= 1'b1;
        state_q   <= IDLE;
      end else if (accept) begin
        if (rx_err && active) begin
          frame_err <= 1'b1;
          state_q   <= IDLE;
        end else begin
          case (state_q)
            IDLE: begin
              if (!rx_err && rx_data == 8'hAA)
                state_q <= SYNC;
            end
            SYNC: begin
              if (rx_data == 8'h55) begin
                state_q <= PAYLOAD;
                sum     <= '0;
                comp    <= '0;
                x_cnt   <= '0;
                y_cnt   <= '0;
              end else if (rx_data != 8'hAA) begin
                state_q <= IDLE;
              end
            end
            PAYLOAD: begin
              sum <= sum + rx_data;
              case (comp)
                2'd0: begin
                  r_buf <= rx_data;
                  comp  <= 2'd1;
                end
                2'd1: begin
                  g_buf <= rx_data;
                  comp  <= 2'd2;
                end
                default: begin
                  pix_red   <= r_buf;
                  pix_green <= g_buf;
                  pix_blue  <= rx_data;
                  pix_x     <= x_cnt;
                  pix_y     <= y_cnt;
                  pix_valid <= 1'b1;
                  comp      <= 2'd0;
                  if (x_cnt == X_LAST) begin
                    x_cnt <= '0;
                    y_cnt <= y_cnt + 10'd1;
                    if (y_cnt == Y_LAST)
                      state_q <= CHECK;
                  end else begin
                    x_cnt <= x_cnt + 10'd1;
                  end
                end
              endcase
            end
            CHECK: begin
              if (rx_data == sum) begin
                frame_done <= 1'b1;
                state_q    <= DONE;
              end else begin
                frame_err <= 1'b1;
                state_q   <= IDLE;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end else if (state_q == DONE) begin
        state_q <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_assembler.sv
// Directed bench: one instance is 2x1 with timeout 100, the other is 3x2.
// Monitors log the strobes on the falling clock edge, and the checks compare them with values worked out by hand.
module tb_uart_rx_frame_assembler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_err = 1'b0;
  logic       done_a = 1'b0;
  logic       done_b = 1'b0;

  logic [7:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic       pv_a, fd_a, fe_a, pv_b, fd_b, fe_b;
  logic [2:0] st_a, st_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [43:0] pa_q[$];
  logic [43:0] pb_q[$];
  int fd_a_n = 0, fe_a_n = 0, fd_b_n = 0, fe_b_n = 0;

  always #5 clk = ~clk;

  uart_rx_frame_assembler #(.WIDTH(2), .HEIGHT(1), .TIMEOUT(100)) dut_a (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(done_a), .rx_err(rx_err),
    .pix_red(red_a), .pix_green(green_a), .pix_blue(blue_a), .pix_x(x_a), .pix_y(y_a),
    .pix_valid(pv_a), .frame_done(fd_a), .frame_err(fe_a), .state(st_a));

  uart_rx_frame_assembler #(.WIDTH(3), .HEIGHT(2), .TIMEOUT(1000)) dut_b (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(done_b), .rx_err(rx_err),
    .pix_red(red_b), .pix_green(green_b), .pix_blue(blue_b), .pix_x(x_b), .pix_y(y_b),
    .pix_valid(pv_b), .frame_done(fd_b), .frame_err(fe_b), .state(st_b));

  always @(negedge clk) begin
    if (pv_a) pa_q.push_back({red_a, green_a, blue_a, x_a, y_a});
    if (pv_b) pb_q.push_back({red_b, green_b, blue_b, x_b, y_b});
    if (fd_a) fd_a_n++;
    if (fe_a) fe_a_n++;
    if (fd_b) fd_b_n++;
    if (fe_b) fe_b_n++;
  end

  function automatic logic [43:0] pk(input logic [7:0] r, g, b, input logic [9:0] x, y);
    return {r, g, b, x, y};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit to_b, input logic [7:0] d, input bit e);
    rx_data = d;
    rx_err  = e;
    if (to_b) done_b = 1'b1; else done_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    done_a = 1'b0;
    done_b = 1'b0;
    rx_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send_seq(input bit to_b, input logic [7:0] seq[$]);
    foreach (seq[i]) send(to_b, seq[i], 1'b0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] fr[$];
    int bp, bd, be;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", st_a, 3'd0);
    check("rst_pix_valid", pv_a, 1'b0);
    check("rst_frame_done", fd_a, 1'b0);
    check("rst_frame_err", fe_a, 1'b0);
    check("rst_pix_red", red_a, 8'h00);
    check("rst_pix_x", x_a, 10'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: good frame
    bp = pa_q.size(); bd = fd_a_n; be = fe_a_n;
    fr = '{8'hAA, 8'h55, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h50};
    send_seq(1'b0, fr);
    check("t1_pix_count", pa_q.size() - bp, 2);
    if (pa_q.size() - bp == 2) begin
      check("t1_pix0", pa_q[bp], pk(8'h10, 8'h20, 8'h30, 10'd0, 10'd0));
      check("t1_pix1", pa_q[bp+1], pk(8'h40, 8'h50, 8'h60, 10'd1, 10'd0));
    end
    check("t1_done", fd_a_n - bd, 1);
    check("t1_err", fe_a_n - be, 0);
    check("t1_pix_hold", {red_a, green_a, blue_a}, 24'h405060);
    check("t1_state", st_a, 3'd0);

    // 2: bad checksum
    bp = pa_q.size(); bd = fd_a_n; be = fe_a_n;
    fr = '{8'hAA, 8'h55, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h51};
    send_seq(1'b0, fr);
    check("t2_pix_count", pa_q.size() - bp, 2);
    check("t2_err", fe_a_n - be, 1);
    check("t2_done", fd_a_n - bd, 0);
    check("t2_state", st_a, 3'd0);

    // 3: leading junk and a repeated header byte
    bp = pa_q.size(); bd = fd_a_n; be = fe_a_n;
    fr = '{8'h12, 8'hAA, 8'hAA, 8'h55, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h50};
    send_seq(1'b0, fr);
    check("t3_pix_count", pa_q.size() - bp, 2);
    check("t3_done", fd_a_n - bd, 1);
    check("t3_err", fe_a_n - be, 0);

    // 4: rx_err on the 4th payload byte, then a clean frame
    bp = pa_q.size(); bd = fd_a_n; be = fe_a_n;
    fr = '{8'hAA, 8'h55, 8'h10, 8'h20, 8'h30};
    send_seq(1'b0, fr);
    send(1'b0, 8'h40, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("t4_pix_count", pa_q.size() - bp, 1);
    check("t4_err", fe_a_n - be, 1);
    check("t4_done", fd_a_n - bd, 0);
    check("t4_state", st_a, 3'd0);
    bd = fd_a_n;
    fr = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'hAA, 8'h05, 8'h06, 8'hBB};
    send_seq(1'b0, fr);
    check("t4_recover_done", fd_a_n - bd, 1);
    check("t4_aa_as_data", pa_q[pa_q.size()-1], pk(8'hAA, 8'h05, 8'h06, 10'd1, 10'd0));

    // 5: timeout after AA 55 10
    be = fe_a_n;
    send(1'b0, 8'hAA, 1'b0);
    send(1'b0, 8'h55, 1'b0);
    send(1'b0, 8'h10, 1'b0);
    repeat (80) @(posedge clk);
    #1;
    check("t5_no_early_err", fe_a_n - be, 0);
    check("t5_state_payload", st_a, 3'd2);
    repeat (30) @(posedge clk);
    #1;
    check("t5_timeout_err", fe_a_n - be, 1);
    check("t5_state", st_a, 3'd0);

    // 6: 3x2 frame, reset after pixel 4, then resend
    fr = '{8'hAA, 8'h55, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12};
    send_seq(1'b1, fr);
    check("t6_pre_rst_x", x_b, 10'd0);
    check("t6_pre_rst_y", y_b, 10'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_x", x_b, 10'd0);
    check("t6_rst_y", y_b, 10'd0);
    check("t6_rst_red", red_b, 8'h00);
    check("t6_rst_state", st_b, 3'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bp = pb_q.size(); bd = fd_b_n; be = fe_b_n;
    fr = '{8'hAA, 8'h55};
    for (int i = 1; i <= 18; i++) fr.push_back(8'(i));
    fr.push_back(8'hAB);
    send_seq(1'b1, fr);
    check("t6_pix_count", pb_q.size() - bp, 6);
    if (pb_q.size() - bp == 6) begin
      for (int p = 0; p < 6; p++)
        check($sformatf("t6_pix%0d", p), pb_q[bp+p],
              pk(8'(3*p+1), 8'(3*p+2), 8'(3*p+3), 10'(p % 3), 10'(p / 3)));
    end
    check("t6_done", fd_b_n - bd, 1);
    check("t6_err", fe_b_n - be, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
